// File: rtl/ksa_shuffle_fsm_if.sv
// -----------------------------------------------------------------------------
// ksa_shuffle_fsm_if
// Bundles the KSA swap engine's sequencer handshake and its single-port
// S-memory bus.
//   start   : request a full KSA pass (sequencer -> engine)
//   key     : secret key, byte 0 in the most significant byte
//   busy    : engine is running a pass
//   done    : one-cycle completion pulse
//   q       : S memory read data (memory -> engine)
//   address : S memory address
//   data    : S memory write data
//   rden    : S memory read enable
//   wren    : S memory write enable
// master = the engine side, slave = sequencer + memory side.
// -----------------------------------------------------------------------------
interface ksa_shuffle_fsm_if #(
    parameter int DATA_W    = 8,
    parameter int KEY_BYTES = 3
);
    logic                   start;
    logic [8*KEY_BYTES-1:0] key;
    logic                   busy;
    logic                   done;
    logic [DATA_W-1:0]      q;
    logic [DATA_W-1:0]      address;
    logic [DATA_W-1:0]      data;
    logic                   rden;
    logic                   wren;

    modport master (
        input  start, key, q,
        output busy, done, address, data, rden, wren
    );

    modport slave (
        output start, key, q,
        input  busy, done, address, data, rden, wren
    );
endinterface

// File: rtl/ksa_shuffle_fsm.sv
// -----------------------------------------------------------------------------
// ksa_shuffle_fsm
// RC4 key-scheduling swap engine. Assumes the S memory already holds S[i]=i.
// For i = 0..DEPTH-1: j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j].
// Each iteration: READ_I, (WAIT_I), CAP_I, READ_J, (WAIT_J), CAP_J, WRITE_I,
// WRITE_J  -> 4 + 2*RD_LAT cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : ksa_shuffle_fsm_if.master (start/key/busy/done handshake and
//           address/data/rden/wren/q memory bus)
// All bus outputs are registers loaded with the decode of the next state, so
// they are Moore outputs that are stable for the whole cycle of each state.
// -----------------------------------------------------------------------------
module ksa_shuffle_fsm #(
    parameter int DATA_W    = 8,
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                reset,
    ksa_shuffle_fsm_if.master   bus
);

    localparam int KEY_W  = 8 * KEY_BYTES;
    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    localparam logic [DATA_W-1:0] I_LAST    = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ONE_D     = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO_D    = {DATA_W{1'b0}};
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
    localparam logic [KIDX_W-1:0] KIDX_ONE  = {{(KIDX_W-1){1'b0}}, 1'b1};
    localparam logic [KIDX_W-1:0] KIDX_ZERO = {KIDX_W{1'b0}};
    // WAIT states last RD_LAT-1 cycles: the counter loads RD_LAT-2 and exits at 0.
    localparam logic [2:0]        WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_READ_I  = 4'd1,
        ST_WAIT_I  = 4'd2,
        ST_CAP_I   = 4'd3,
        ST_READ_J  = 4'd4,
        ST_WAIT_J  = 4'd5,
        ST_CAP_J   = 4'd6,
        ST_WRITE_I = 4'd7,
        ST_WRITE_J = 4'd8,
        ST_DONE    = 4'd9
    } state_t;

    state_t              state_r, state_s;
    logic [DATA_W-1:0]   i_r, i_s;
    logic [DATA_W-1:0]   j_r, j_s;
    logic [DATA_W-1:0]   si_r, si_s;
    logic [DATA_W-1:0]   sj_r, sj_s;
    logic [KIDX_W-1:0]   kidx_r, kidx_s;
    logic [2:0]          wait_r, wait_s;
    logic [KEY_W-1:0]    key_r, key_s;
    logic [DATA_W-1:0]   address_r, address_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic                rden_r, rden_s;
    logic                wren_r, wren_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic [KEY_W-1:0]    key_shift_s;
    logic [DATA_W-1:0]   key_byte_s;

    // Key byte select: shift the wanted byte to the top instead of dividing i.
    always_comb begin
        key_shift_s = key_r << {kidx_r, 3'b000};
        key_byte_s  = DATA_W'(key_shift_s[KEY_W-1 -: 8]);
    end

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_s = state_r;
        i_s     = i_r;
        j_s     = j_r;
        si_s    = si_r;
        sj_s    = sj_r;
        kidx_s  = kidx_r;
        wait_s  = wait_r;
        key_s   = key_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    key_s   = bus.key;
                    i_s     = ZERO_D;
                    j_s     = ZERO_D;
                    kidx_s  = KIDX_ZERO;
                    state_s = ST_READ_I;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ_I: begin
                if (RD_LAT > 1) begin
                    wait_s  = WAIT_INIT;
                    state_s = ST_WAIT_I;
                end else begin
                    state_s = ST_CAP_I;
                end
            end
            ST_WAIT_I: begin
                if (wait_r == 3'd0) begin
                    state_s = ST_CAP_I;
                end else begin
                    wait_s = wait_r - 3'd1;
                end
            end
            ST_CAP_I: begin
                si_s    = bus.q;
                j_s     = j_r + bus.q + key_byte_s;
                state_s = ST_READ_J;
            end
            ST_READ_J: begin
                if (RD_LAT > 1) begin
                    wait_s  = WAIT_INIT;
                    state_s = ST_WAIT_J;
                end else begin
                    state_s = ST_CAP_J;
                end
            end
            ST_WAIT_J: begin
                if (wait_r == 3'd0) begin
                    state_s = ST_CAP_J;
                end else begin
                    wait_s = wait_r - 3'd1;
                end
            end
            ST_CAP_J: begin
                sj_s    = bus.q;
                state_s = ST_WRITE_I;
            end
            ST_WRITE_I: begin
                state_s = ST_WRITE_J;
            end
            ST_WRITE_J: begin
                if (i_r == I_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    i_s     = i_r + ONE_D;
                    kidx_s  = (kidx_r == KIDX_LAST) ? KIDX_ZERO : (kidx_r + KIDX_ONE);
                    state_s = ST_READ_I;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs for the state being entered, using the post-update registers
        // so READ_J presents the freshly computed j.
        address_s = address_r;
        data_s    = data_r;
        rden_s    = 1'b0;
        wren_s    = 1'b0;
        busy_s    = 1'b1;
        done_s    = 1'b0;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_READ_I: begin
                address_s = i_s;
                rden_s    = 1'b1;
            end
            ST_READ_J: begin
                address_s = j_s;
                rden_s    = 1'b1;
            end
            ST_WRITE_I: begin
                address_s = i_s;
                data_s    = sj_s;
                wren_s    = 1'b1;
            end
            ST_WRITE_J: begin
                address_s = j_s;
                data_s    = si_s;
                wren_s    = 1'b1;
            end
            ST_DONE: begin
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers; reset clears everything at once so
    // an in-flight write is dropped immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            i_r       <= ZERO_D;
            j_r       <= ZERO_D;
            si_r      <= ZERO_D;
            sj_r      <= ZERO_D;
            kidx_r    <= KIDX_ZERO;
            wait_r    <= 3'd0;
            key_r     <= {KEY_W{1'b0}};
            address_r <= ZERO_D;
            data_r    <= ZERO_D;
            rden_r    <= 1'b0;
            wren_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            i_r       <= i_s;
            j_r       <= j_s;
            si_r      <= si_s;
            sj_r      <= sj_s;
            kidx_r    <= kidx_s;
            wait_r    <= wait_s;
            key_r     <= key_s;
            address_r <= address_s;
            data_r    <= data_s;
            rden_r    <= rden_s;
            wren_r    <= wren_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign bus.address = address_r;
    assign bus.data    = data_r;
    assign bus.rden    = rden_r;
    assign bus.wren    = wren_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule

// File: doc/ksa_shuffle_fsm.md
Name: ksa_shuffle_fsm

Overview:
Parametrised RC4 key-scheduling (KSA) swap engine; next generation of the S-array shuffle controller. Runs after the S-array init pass (S[i]=i) has filled the single-port S memory. Performs, for i = 0..DEPTH-1: j = j + S[i] + key[i mod KEY_BYTES], then swaps S[i] and S[j]. Drives the S memory address/data/rden/wren directly and reports completion to the top-level sequencer with a start/done handshake.

Parameters:
DATA_W, 8, byte/address width; DEPTH = 2^DATA_W entries; all index arithmetic is modulo 2^DATA_W
KEY_BYTES, 3, secret-key length in bytes
RD_LAT, 1, memory read latency in cycles (1..4): q valid RD_LAT cycles after the cycle address+rden are driven

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request: begin a full KSA pass; sampled only in IDLE
key  input  8*KEY_BYTES  secret key; byte k = key[8*KEY_BYTES-1-8k -: 8] (byte 0 is MSB byte); captured on accepted start
q  input  DATA_W  S memory read data
address  output  DATA_W  S memory address
data  output  DATA_W  S memory write data
rden  output  1  S memory read enable
wren  output  1  S memory write enable
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the pass completes

Behaviour:
- Reset (async, any state, including mid-pass): state=IDLE; i=0, j=0; address=0, data=0, rden=0, wren=0, busy=0, done=0; captured key cleared. No partial write completes after reset asserts.
- Outputs are Moore, decoded from state and internal registers; valid for the whole cycle the state is occupied.
- States and per-cycle bus activity:
  IDLE: rden=0, wren=0, busy=0. If start=1: capture key, i<=0, j<=0 -> READ_I. Otherwise stay.
  READ_I: address=i, rden=1 -> WAIT_I (RD_LAT-1 cycles; skipped when RD_LAT=1) -> CAP_I.
  CAP_I: si<=q; j<=j+q+key[i mod KEY_BYTES] (DATA_W-bit wrap) -> READ_J.
  READ_J: address=j (new value), rden=1 -> WAIT_J (RD_LAT-1 cycles) -> CAP_J.
  CAP_J: sj<=q -> WRITE_I.
  WRITE_I: address=i, data=sj, wren=1, rden=0 -> WRITE_J.
  WRITE_J: address=j, data=si, wren=1. If i==DEPTH-1 -> DONE, else i<=i+1 -> READ_I.
  DONE: done=1, busy=0, wren=0 for exactly one cycle -> IDLE.
- Cycles per iteration = 4+2*RD_LAT (6 at defaults). If start is accepted at cycle 0, the first READ_I is cycle 1 and done is high in cycle 1+DEPTH*(4+2*RD_LAT) (1537 at defaults).
- i==j: both writes target the same address with the same value; the net result is S unchanged. This case is not special-cased.
- Key index: a counter wraps at KEY_BYTES. No divider is used. The counter resets to 0 on each accepted start.
- start while busy, or in DONE: ignored. start high in the cycle after DONE (IDLE) begins a new pass.
- rden and wren are never high in the same cycle.
- busy is high in every state except IDLE and DONE.

Test Plan:
- Memory model preloaded S[i]=i, key=24'h000249, start pulse -> writes observed: (addr0,data00),(addr0,data00); (addr01,data03),(addr03,data01); (addr02,data4E),(addr4E,data02).
- Full pass, key=24'h000249 -> done in cycle 1537 after start; final 256-byte S matches a C/Python KSA model; busy is high for exactly 1536 cycles.
- RD_LAT=2 build, same key -> 8 cycles/iteration; done at cycle 2049; identical final S contents.
- KEY_BYTES=5, key=40'h0102030405 -> key index sequence 0,1,2,3,4,0,... verified against the model; final S matches.
- Assert reset at iteration 100 during WRITE_I -> all outputs 0 within the same cycle; state IDLE; start after reset release runs a clean pass.
- start pulsed repeatedly while busy -> no restart and no extra done; exactly one done per accepted start.
